// File: rtl/seq_mult_pkg.sv
// Shared types and sizes for the sequential shift-and-add multiplier.
package seq_mult_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_32b_add_64b.sv
// Combinational accumulate adder used by seq_mult_32b.
module add_64b
  import seq_mult_pkg::*;
#(
  parameter int unsigned W = PROD_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum
);

  always_comb begin
    sum = x + y;
  end

endmodule

// File: rtl/seq_mult_32b.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per RUN cycle.
// Optional macro SEQ_MULT_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are all zero.
module seq_mult_32b
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t            state, state_next;
  logic [PW-1:0]     mcand;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     addend;
  logic [PW-1:0]     sum;
  logic [WIDTH-1:0]  mplr;
  logic [WIDTH-1:0]  mplr_sh;
  logic [CW-1:0]     cnt;
  logic              run_last;

  always_comb begin
    addend  = mplr[0] ? mcand : '0;
    mplr_sh = mplr >> 1;
  end

  add_64b #(.W(PW)) u_add (
    .x   (acc),
    .y   (addend),
    .sum (sum)
  );

  always_comb begin
`ifdef SEQ_MULT_EARLY_EXIT_EN
    run_last = (cnt == CNT_LAST) || (mplr_sh == '0);
`else
    run_last = (cnt == CNT_LAST);
`endif
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (run_last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplr    <= '0;
      cnt     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= {{WIDTH{1'b0}}, a};
            mplr  <= b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= sum;
          mcand <= mcand << 1;
          mplr  <= mplr_sh;
          cnt   <= cnt + 1'b1;
          // sum already includes this cycle's partial product
          if (run_last) product <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule
